// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares the single data-memory port between the MEM-stage
//            pipeline (priority) and a debug requester that can issue single
//            reads/writes or a whole-memory dump burst. A pending debug
//            request that waits MAX_WAIT cycles forces a pipeline stall.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  // pipeline side
  input  logic              pipeMemRead,
  input  logic              pipeMemWrite,
  input  logic [ADDR_W-1:0] pipeAddr,
  input  logic [DATA_W-1:0] pipeWriteData,
  output logic [DATA_W-1:0] pipeReadData,
  output logic              stallOut,
  // debug side
  input  logic              dbgReq,
  input  logic              dbgWrite,
  input  logic              dbgBurst,
  input  logic [ADDR_W-1:0] dbgAddr,
  input  logic [DATA_W-1:0] dbgWriteData,
  output logic              dbgAck,
  output logic              dbgValid,
  output logic [DATA_W-1:0] dbgReadData,
  output logic [ADDR_W-1:0] dbgReadAddr,
  output logic              dbgDone,
  // memory side
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDin,
  input  logic [DATA_W-1:0] memDout
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [1:0] ST_PIPE   = 2'd0;
  localparam logic [1:0] ST_SINGLE = 2'd1;
  localparam logic [1:0] ST_BURST  = 2'd2;

  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [ADDR_W-1:0] BURST_LAST = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic [ADDR_W-1:0] burstCnt_q, burstCnt_d;

  // debug request fields captured at grant time
  logic              latWrite_q;
  logic [ADDR_W-1:0] latAddr_q;
  logic [DATA_W-1:0] latData_q;

  logic              dbgAck_q;
  logic              dbgValid_q;
  logic              dbgDone_q;
  logic [ADDR_W-1:0] dbgReadAddr_q;
  logic [DATA_W-1:0] dbgReadData_q;

  logic w_pipeActive;
  logic w_grant;
  logic w_singleRead;
  logic w_burstLast;

  assign w_pipeActive = pipeMemRead | pipeMemWrite;
  // The pipeline keeps priority unless the debug side has waited long enough.
  assign w_grant      = (state_q == ST_PIPE) && dbgReq &&
                        (!w_pipeActive || (waitCnt_q == WAIT_LAST));
  assign w_singleRead = (state_q == ST_SINGLE) && !latWrite_q;
  assign w_burstLast  = (state_q == ST_BURST) && (burstCnt_q == BURST_LAST);

  // Next-state logic for the ownership FSM and its two counters.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    burstCnt_d = burstCnt_q;
    case (state_q)
      ST_PIPE: begin
        if (w_grant) begin
          state_d    = dbgBurst ? ST_BURST : ST_SINGLE;
          waitCnt_d  = '0;
          burstCnt_d = '0;
        end else if (dbgReq) begin
          waitCnt_d = waitCnt_q + 1'b1;
        end else begin
          waitCnt_d = '0;
        end
      end
      ST_SINGLE: begin
        state_d   = ST_PIPE;
        waitCnt_d = '0;
      end
      ST_BURST: begin
        waitCnt_d = '0;
        if (burstCnt_q == BURST_LAST) begin
          burstCnt_d = '0;
          state_d    = ST_PIPE;
        end else begin
          burstCnt_d = burstCnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_PIPE;
        waitCnt_d  = '0;
        burstCnt_d = '0;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_PIPE;
      waitCnt_q  <= '0;
      burstCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      burstCnt_q <= burstCnt_d;
    end
  end

  // Capture the debug request at grant so the requester may release it.
  always_ff @(posedge clk) begin
    if (reset) begin
      latWrite_q <= 1'b0;
      latAddr_q  <= '0;
      latData_q  <= '0;
    end else if (w_grant) begin
      latWrite_q <= dbgWrite;
      latAddr_q  <= dbgAddr;
      latData_q  <= dbgWriteData;
    end
  end

  // Memory port mux: pipeline by default, debug while it owns the port.
  always_comb begin
    memWe   = pipeMemWrite;
    memAddr = pipeAddr;
    memDin  = pipeWriteData;
    case (state_q)
      ST_SINGLE: begin
        memWe   = latWrite_q;
        memAddr = latAddr_q;
        memDin  = latData_q;
      end
      ST_BURST: begin
        memWe   = 1'b0;
        memAddr = burstCnt_q;
        memDin  = latData_q;
      end
      default: ;
    endcase
  end

  assign stallOut     = (state_q != ST_PIPE);
  assign pipeReadData = memDout;

  // Debug handshake and read-return registers; a reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbgAck_q      <= 1'b0;
      dbgValid_q    <= 1'b0;
      dbgDone_q     <= 1'b0;
      dbgReadAddr_q <= '0;
      dbgReadData_q <= '0;
    end else begin
      dbgAck_q   <= w_grant;
      dbgValid_q <= w_singleRead || (state_q == ST_BURST);
      dbgDone_q  <= (w_grant && !dbgBurst && dbgWrite) || w_singleRead || w_burstLast;
      if (w_singleRead) begin
        dbgReadAddr_q <= latAddr_q;
      end else if (state_q == ST_BURST) begin
        dbgReadAddr_q <= burstCnt_q;
      end
      if (dbgValid_q) begin
        dbgReadData_q <= memDout;
      end
    end
  end

  // The memory answers one cycle after the address, which is exactly the
  // dbgValid cycle, so the live word is forwarded and the last one is held.
  assign dbgAck      = dbgAck_q;
  assign dbgValid    = dbgValid_q;
  assign dbgDone     = dbgDone_q;
  assign dbgReadAddr = dbgReadAddr_q;
  assign dbgReadData = dbgValid_q ? memDout : dbgReadData_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter with a behavioural
//            memory, a timeline-based reference model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              pipeMemRead, pipeMemWrite;
  logic [ADDR_W-1:0] pipeAddr;
  logic [DATA_W-1:0] pipeWriteData, pipeReadData;
  logic              stallOut;
  logic              dbgReq, dbgWrite, dbgBurst;
  logic [ADDR_W-1:0] dbgAddr;
  logic [DATA_W-1:0] dbgWriteData;
  logic              dbgAck, dbgValid, dbgDone;
  logic [DATA_W-1:0] dbgReadData;
  logic [ADDR_W-1:0] dbgReadAddr;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDin, memDout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .pipeMemRead(pipeMemRead), .pipeMemWrite(pipeMemWrite),
    .pipeAddr(pipeAddr), .pipeWriteData(pipeWriteData),
    .pipeReadData(pipeReadData), .stallOut(stallOut),
    .dbgReq(dbgReq), .dbgWrite(dbgWrite), .dbgBurst(dbgBurst),
    .dbgAddr(dbgAddr), .dbgWriteData(dbgWriteData),
    .dbgAck(dbgAck), .dbgValid(dbgValid), .dbgReadData(dbgReadData),
    .dbgReadAddr(dbgReadAddr), .dbgDone(dbgDone),
    .memWe(memWe), .memAddr(memAddr), .memDin(memDin), .memDout(memDout)
  );

  // Synchronous-read data memory standing in for Memoria.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    memDout <= mem[memAddr];
    if (memWe) mem[memAddr] <= memDin;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Debug ownership is an interval of cycle numbers [own_lo, own_hi]; read
  // returns and done pulses are scheduled events keyed by cycle number.
  typedef struct {
    int              at;
    bit              valid;
    bit              done;
    logic [ADDR_W-1:0] addr;
  } ev_t;

  ev_t               evq[$];
  bit                live = 1'b0;
  int                own_lo = -10;
  int                own_hi = -20;
  bit                own_burst = 1'b0;
  bit                lat_wr = 1'b0;
  logic [ADDR_W-1:0] lat_addr = '0;
  logic [DATA_W-1:0] lat_data = '0;
  int                waited = 0;
  int                ack_at = -1;
  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic [DATA_W-1:0] m_dout = '0;
  bit                m_dout_known = 1'b0;

  always @(negedge clk) begin : p_model
    bit                owned, e_we, e_valid, e_done;
    logic [ADDR_W-1:0] e_addr, e_raddr;
    logic [DATA_W-1:0] e_din;
    ev_t               e;
    if (!live) begin
      if (reset) begin
        live         = 1'b1;
        own_lo       = -10;
        own_hi       = -20;
        waited       = 0;
        m_dout_known = 1'b0;
        evq.delete();
      end
    end else begin
      owned = (cyc >= own_lo) && (cyc <= own_hi);
      if (owned) begin
        e_we   = !own_burst && lat_wr;
        e_addr = own_burst ? ADDR_W'(cyc - own_lo) : lat_addr;
        e_din  = lat_data;
      end else begin
        e_we   = pipeMemWrite;
        e_addr = pipeAddr;
        e_din  = pipeWriteData;
      end
      e_valid = 1'b0;
      e_done  = 1'b0;
      e_raddr = '0;
      foreach (evq[i]) begin
        if (evq[i].at == cyc) begin
          if (evq[i].valid) begin
            e_valid = 1'b1;
            e_raddr = evq[i].addr;
          end
          if (evq[i].done) e_done = 1'b1;
        end
      end

      check("m_stallOut", 32'(stallOut), 32'(owned));
      check("m_dbgAck",   32'(dbgAck),   32'(cyc == own_lo));
      check("m_memWe",    32'(memWe),    32'(e_we));
      check("m_memAddr",  32'(memAddr),  32'(e_addr));
      if (e_we) check("m_memDin", memDin, e_din);
      if (m_dout_known) check("m_pipeReadData", pipeReadData, m_dout);
      check("m_dbgValid", 32'(dbgValid), 32'(e_valid));
      check("m_dbgDone",  32'(dbgDone),  32'(e_done));
      if (e_valid) begin
        check("m_dbgReadAddr", 32'(dbgReadAddr), 32'(e_raddr));
        check("m_dbgReadData", dbgReadData, exp_mem[e_raddr]);
      end

      // effect of the coming clock edge
      m_dout       = exp_mem[e_addr];
      m_dout_known = 1'b1;
      if (e_we) exp_mem[e_addr] = e_din;
      while (evq.size() > 0 && evq[0].at <= cyc) void'(evq.pop_front());

      if (reset) begin
        own_lo = -10;
        own_hi = -20;
        waited = 0;
        evq.delete();
      end else if (!owned && dbgReq) begin
        if (!(pipeMemRead || pipeMemWrite) || waited == MAX_WAIT - 1) begin
          own_lo    = cyc + 1;
          own_hi    = cyc + (dbgBurst ? DEPTH : 1);
          own_burst = dbgBurst;
          lat_wr    = dbgWrite;
          lat_addr  = dbgAddr;
          lat_data  = dbgWriteData;
          ack_at    = cyc + 1;
          waited    = 0;
          if (dbgBurst) begin
            for (int k = 0; k < DEPTH; k++) begin
              e.at = cyc + 2 + k; e.valid = 1'b1; e.done = (k == DEPTH - 1);
              e.addr = ADDR_W'(k);
              evq.push_back(e);
            end
          end else if (dbgWrite) begin
            e.at = cyc + 1; e.valid = 1'b0; e.done = 1'b1; e.addr = dbgAddr;
            evq.push_back(e);
          end else begin
            e.at = cyc + 2; e.valid = 1'b1; e.done = 1'b1; e.addr = dbgAddr;
            evq.push_back(e);
          end
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Advance to just after the next edge; the requester drops dbgReq on ack.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (cyc == ack_at) dbgReq = 1'b0;
  endtask

  initial begin : p_stim
    int n, stalls;
    bit found, seen;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    reset = 1'b1;
    pipeMemRead = 1'b0; pipeMemWrite = 1'b0; pipeAddr = '0; pipeWriteData = '0;
    dbgReq = 1'b0; dbgWrite = 1'b0; dbgBurst = 1'b0; dbgAddr = '0; dbgWriteData = '0;
    repeat (2) next_cycle();
    reset = 1'b0;

    // reset state and PIPE muxing
    pipeAddr = 4'hA; pipeWriteData = 32'h55;
    @(negedge clk);
    check("rst_stallOut", 32'(stallOut), 32'd0);
    check("rst_dbgAck", 32'(dbgAck), 32'd0);
    check("rst_dbgValid", 32'(dbgValid), 32'd0);
    check("rst_dbgDone", 32'(dbgDone), 32'd0);
    check("rst_dbgReadData", dbgReadData, 32'd0);
    check("rst_dbgReadAddr", 32'(dbgReadAddr), 32'd0);
    check("rst_memAddr", 32'(memAddr), 32'hA);
    check("rst_memDin", memDin, 32'h55);
    check("rst_memWe", 32'(memWe), 32'd0);

    // idle single write then read-back
    next_cycle();
    pipeAddr = '0; pipeWriteData = '0;
    dbgReq = 1'b1; dbgWrite = 1'b1; dbgBurst = 1'b0; dbgAddr = 4'd5; dbgWriteData = 32'hDEADBEEF;
    next_cycle();
    @(negedge clk);
    check("wr_ack", 32'(dbgAck), 32'd1);
    check("wr_done", 32'(dbgDone), 32'd1);
    check("wr_memWe", 32'(memWe), 32'd1);
    check("wr_memAddr", 32'(memAddr), 32'd5);
    check("wr_memDin", memDin, 32'hDEADBEEF);
    check("wr_stall", 32'(stallOut), 32'd1);
    next_cycle();
    @(negedge clk);
    check("wr_stall_end", 32'(stallOut), 32'd0);
    next_cycle();
    dbgReq = 1'b1; dbgWrite = 1'b0; dbgAddr = 4'd5;
    next_cycle();
    @(negedge clk);
    check("rd_ack", 32'(dbgAck), 32'd1);
    check("rd_memAddr", 32'(memAddr), 32'd5);
    check("rd_memWe", 32'(memWe), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rd_valid", 32'(dbgValid), 32'd1);
    check("rd_done", 32'(dbgDone), 32'd1);
    check("rd_data", dbgReadData, 32'hDEADBEEF);
    check("rd_addr", 32'(dbgReadAddr), 32'd5);

    // starvation: busy pipeline, grant forced after MAX_WAIT cycles
    next_cycle();
    pipeMemRead = 1'b1; pipeAddr = 4'hC;
    dbgReq = 1'b1; dbgWrite = 1'b0; dbgAddr = 4'd3;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      check("starve_stall", 32'(stallOut), 32'd0);
      check("starve_ack", 32'(dbgAck), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check("starve_grant_ack", 32'(dbgAck), 32'd1);
    check("starve_grant_stall", 32'(stallOut), 32'd1);
    check("starve_grant_addr", 32'(memAddr), 32'd3);
    next_cycle();
    pipeMemRead = 1'b0;
    repeat (3) next_cycle();

    // preload word k = k*0x11 through the pipeline, then dump
    for (int k = 0; k < DEPTH; k++) begin
      pipeMemWrite = 1'b1; pipeAddr = ADDR_W'(k); pipeWriteData = 32'(k) * 32'h11;
      next_cycle();
    end
    pipeMemWrite = 1'b0; pipeAddr = '0;
    dbgReq = 1'b1; dbgBurst = 1'b1;
    n = 0; stalls = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (stallOut) stalls++;
      if (dbgValid) begin
        check("burst_addr", 32'(dbgReadAddr), 32'(n));
        check("burst_data", dbgReadData, 32'(n) * 32'h11);
        check("burst_done", 32'(dbgDone), 32'(n == DEPTH - 1));
        n++;
      end
      next_cycle();
    end
    check("burst_words", 32'(n), 32'd16);
    check("burst_stalls", 32'(stalls), 32'd16);

    // reset in the middle of a burst
    dbgReq = 1'b1; dbgBurst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!found) begin
        @(negedge clk);
        if (stallOut && memAddr == 4'd5) found = 1'b1;
        next_cycle();
      end
    end
    check("rstb_found", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstb_word6", 32'(memAddr), 32'd6);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rstb_stall", 32'(stallOut), 32'd0);
    check("rstb_valid", 32'(dbgValid), 32'd0);
    check("rstb_done", 32'(dbgDone), 32'd0);
    next_cycle();
    dbgReq = 1'b1; dbgBurst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (dbgValid && !seen) begin
        seen = 1'b1;
        check("rstb_restart_addr", 32'(dbgReadAddr), 32'd0);
        check("rstb_restart_data", dbgReadData, 32'd0);
      end
      next_cycle();
    end
    check("rstb_restart_seen", 32'(seen), 32'd1);
    dbgBurst = 1'b0;

    // pipeline passthrough
    pipeMemWrite = 1'b1; pipeAddr = 4'd9; pipeWriteData = 32'h12345678;
    @(negedge clk);
    check("pass_stall_wr", 32'(stallOut), 32'd0);
    next_cycle();
    pipeMemWrite = 1'b0; pipeMemRead = 1'b1;
    @(negedge clk);
    check("pass_stall_rd", 32'(stallOut), 32'd0);
    next_cycle();
    pipeMemRead = 1'b0;
    @(negedge clk);
    check("pass_data", pipeReadData, 32'h12345678);
    check("pass_stall_after", 32'(stallOut), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      pipeMemRead   = ($urandom_range(2) == 0);
      pipeMemWrite  = ($urandom_range(2) == 0);
      pipeAddr      = ADDR_W'($urandom);
      pipeWriteData = $urandom;
      reset         = ($urandom_range(399) == 0);
      if (!dbgReq && cyc != ack_at && $urandom_range(7) == 0) begin
        dbgReq       = 1'b1;
        dbgBurst     = ($urandom_range(4) == 0);
        dbgWrite     = $urandom_range(1) == 1;
        dbgAddr      = ADDR_W'($urandom);
        dbgWriteData = $urandom;
      end
    end
    reset = 1'b0; pipeMemRead = 1'b0; pipeMemWrite = 1'b0;
    repeat (40) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
